decoder_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 4-to-16 decoder's single select path among 16 requesters. It drives the decoder's `en`/`s` inputs and a matching registered one-hot `gnt` vector. Each grant is held while its requester keeps requesting, but for at most `MAX_HOLD` cycles when others are waiting. It sits between the requesting agents and the decoder and is the only block allowed to drive the decoder's select.

---
 rtl/decoder_rr_arbiter_if.sv | 11 +
 rtl/decoder_rr_arbiter.sv | 104 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting agents and the decoder arbiter.
// master = requester side, slave = arbiter side.
interface decoder_rr_arbiter_if;
  logic [15:0] req;
  logic        en;
  logic [3:0]  s;
  logic [15:0] gnt;

  modport master (output req, input en, s, gnt);
  modport slave  (input req, output en, s, gnt);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter owning the 4-to-16 decoder's select path; grants are
// held while requested but capped at MAX_HOLD cycles under contention.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [7:0]  r_hold_cnt;
  logic        r_en;
  logic [3:0]  r_s;
  logic [15:0] r_gnt;

  logic [3:0]  w_scan_idx [16];
  logic [15:0] w_rot;
  logic [3:0]  w_next_idx;
  logic        w_any_req;
  logic        w_holder_req;
  logic        w_others;

  // w_rot[gi] is the request seen gi+1 positions after ptr, so the lowest
  // set bit of w_rot is the round-robin winner; ptr itself is checked last.
  for (genvar gi = 0; gi < 16; gi++) begin : g_scan
    assign w_scan_idx[gi] = r_ptr + 4'(gi + 1);
    assign w_rot[gi]      = bus.req[w_scan_idx[gi]];
  end

  always_comb begin
    w_next_idx = r_ptr;
    for (int k = 15; k >= 0; k--) begin
      if (w_rot[k]) w_next_idx = w_scan_idx[k];
    end
  end

  assign w_any_req    = |bus.req;
  assign w_holder_req = bus.req[r_s];
  assign w_others     = |(bus.req & ~(16'h0001 << r_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= 4'd15;
      r_hold_cnt <= 8'd0;
      r_en       <= 1'b0;
      r_s        <= 4'd0;
      r_gnt      <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= GRANT;
            r_en       <= 1'b1;
            r_s        <= w_next_idx;
            r_gnt      <= 16'h0001 << w_next_idx;
            r_ptr      <= w_next_idx;
            r_hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (!w_holder_req) begin
            if (w_any_req) begin
              // Holder released while others wait: hand off with no idle gap.
              r_s        <= w_next_idx;
              r_gnt      <= 16'h0001 << w_next_idx;
              r_ptr      <= w_next_idx;
              r_hold_cnt <= 8'd1;
            end else begin
              r_state    <= IDLE;
              r_en       <= 1'b0;
              r_gnt      <= 16'h0000;
              r_hold_cnt <= 8'd0;
            end
          end else if (r_hold_cnt < HOLD_LIMIT) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end else if (w_others) begin
            r_s        <= w_next_idx;
            r_gnt      <= 16'h0001 << w_next_idx;
            r_ptr      <= w_next_idx;
            r_hold_cnt <= 8'd1;
          end
          // Otherwise the sole requester keeps the grant; hold_cnt saturates.
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_gnt   <= 16'h0000;
        end
      endcase
    end
  end

  assign bus.en  = r_en;
  assign bus.s   = r_s;
  assign bus.gnt = r_gnt;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with hand-computed expectations and a
// per-cycle grant/enable/select consistency check.
module tb_decoder_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en_e, input logic [3:0] s_e,
                         input logic [15:0] gnt_e);
    chk({tag, ".en"},  32'(bus.en),  32'(en_e));
    chk({tag, ".s"},   32'(bus.s),   32'(s_e));
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(gnt_e));
  endtask

  // Consistency of the three outputs, sampled mid-cycle every cycle.
  always @(negedge clk) begin
    chk("inv.gnt_vs_en_s", 32'(bus.gnt), bus.en ? (32'h1 << bus.s) : 32'h0);
  end

  initial begin
    logic [15:0] exp_g;
    logic [3:0]  exp_s;

    rst_n   = 1'b0;
    bus.req = 16'h0000;
    #1;
    chk_out("reset.init", 1'b0, 4'd0, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_out("idle.noreq", 1'b0, 4'd0, 16'h0000);

    // Single request from IDLE, then drop it.
    bus.req = 16'h0010;
    step();
    chk_out("single.grant", 1'b1, 4'd4, 16'h0010);
    bus.req = 16'h0000;
    step();
    chk_out("single.release", 1'b0, 4'd4, 16'h0000);

    // Asynchronous reset mid-grant with s=7.
    bus.req = 16'h0080;
    step();
    chk_out("pre_reset.grant7", 1'b1, 4'd7, 16'h0080);
    rst_n = 1'b0;
    bus.req = 16'h0000;
    #2;
    chk_out("async_reset", 1'b0, 4'd0, 16'h0000);
    step();
    rst_n = 1'b1;
    step();

    // Fairness and no-gap handoff.
    bus.req = 16'h8001;
    step();
    chk_out("fair.first0", 1'b1, 4'd0, 16'h0001);
    bus.req = 16'h8000;
    step();
    chk_out("fair.handoff15", 1'b1, 4'd15, 16'h8000);
    bus.req = 16'h0000;
    step();
    chk_out("fair.idle", 1'b0, 4'd15, 16'h0000);

    // Hold limit: 8 cycles each, alternating 0 and 4 (ptr=15, so 0 first).
    bus.req = 16'h0011;
    for (int c = 1; c <= 32; c++) begin
      step();
      exp_g = (((c - 1) / 8) % 2 == 0) ? 16'h0001 : 16'h0010;
      exp_s = (((c - 1) / 8) % 2 == 0) ? 4'd0 : 4'd4;
      chk_out($sformatf("hold.c%0d", c), 1'b1, exp_s, exp_g);
    end
    bus.req = 16'h0000;
    step();
    chk_out("hold.idle", 1'b0, 4'd4, 16'h0000);

    // Saturation: sole requester keeps the grant indefinitely.
    bus.req = 16'h8000;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk_out($sformatf("sat.c%0d", c), 1'b1, 4'd15, 16'h8000);
    end
    bus.req = 16'h0000;
    step();
    chk_out("sat.idle", 1'b0, 4'd15, 16'h0000);

    // Wrap: park ptr at 14, then 15 -> 0 -> 1 under constant contention.
    bus.req = 16'h4000;
    step();
    chk_out("wrap.grant14", 1'b1, 4'd14, 16'h4000);
    bus.req = 16'h0000;
    step();
    chk_out("wrap.idle14", 1'b0, 4'd14, 16'h0000);
    bus.req = 16'h8003;
    for (int c = 1; c <= 24; c++) begin
      step();
      case ((c - 1) / 8)
        0:       begin exp_s = 4'd15; exp_g = 16'h8000; end
        1:       begin exp_s = 4'd0;  exp_g = 16'h0001; end
        default: begin exp_s = 4'd1;  exp_g = 16'h0002; end
      endcase
      chk_out($sformatf("wrap.c%0d", c), 1'b1, exp_s, exp_g);
    end
    // Holder 1 wraps back to 15 after its 8 cycles.
    step();
    chk_out("wrap.back15", 1'b1, 4'd15, 16'h8000);

    // Simultaneous release by holder with a new request waiting.
    bus.req = 16'h0040;
    step();
    chk_out("release.to6", 1'b1, 4'd6, 16'h0040);
    bus.req = 16'h0000;
    step();
    chk_out("final.idle", 1'b0, 4'd6, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
